// File: rtl/synchronous_down_counter_if.sv
// Signal bundle for the down counter: key/load/din/anode inputs and the
// count, segment, borrow and anode outputs.
interface synchronous_down_counter_if;
    logic       key_i;
    logic       load;
    logic [3:0] din;
    logic [3:0] an;
    logic [3:0] ano;
    logic [3:0] count;
    logic [6:0] leds;
    logic       borrow;

    modport master (
        output key_i, load, din, an,
        input  ano, count, leds, borrow
    );

    modport slave (
        input  key_i, load, din, an,
        output ano, count, leds, borrow
    );
endinterface

// File: rtl/synchronous_down_counter.sv
// 4-bit down counter stepped by a debounced key, with synchronous load,
// wrap borrow pulse and 7-segment decode of the count.
module synchronous_down_counter #(
    parameter int unsigned DEBOUNCE_CYCLES = 20000
) (
    input  logic                      system_clk,
    input  logic                      reset,
    synchronous_down_counter_if.slave bus
);
    localparam int unsigned STAB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(DEBOUNCE_CYCLES - 1);

    logic              k1_q, k1_d;
    logic              k2_q, k2_d;
    logic              kdb_q, kdb_d;
    logic              kdb_dly_q, kdb_dly_d;
    logic [STAB_W-1:0] stab_q, stab_d;
    logic [3:0]        count_q, count_d;
    logic              borrow_q, borrow_d;
    logic              step;

    always_comb begin
        k1_d      = bus.key_i;
        k2_d      = k1_q;
        kdb_d     = kdb_q;
        kdb_dly_d = kdb_q;
        stab_d    = '0;
        // Any return of k2 to the accepted level falls through with stab cleared.
        if (k2_q != kdb_q) begin
            if (stab_q == STAB_MAX) begin
                kdb_d = k2_q;
            end else begin
                stab_d = stab_q + 1'b1;
            end
        end

        step     = kdb_q & ~kdb_dly_q;
        count_d  = count_q;
        borrow_d = 1'b0;
        if (bus.load) begin
            count_d = bus.din;
        end else if (step) begin
            count_d  = count_q - 4'd1;
            borrow_d = (count_q == 4'd0);
        end
    end

    always_ff @(posedge system_clk) begin
        if (reset) begin
            k1_q      <= 1'b0;
            k2_q      <= 1'b0;
            kdb_q     <= 1'b0;
            kdb_dly_q <= 1'b0;
            stab_q    <= '0;
            count_q   <= '0;
            borrow_q  <= 1'b0;
        end else begin
            k1_q      <= k1_d;
            k2_q      <= k2_d;
            kdb_q     <= kdb_d;
            kdb_dly_q <= kdb_dly_d;
            stab_q    <= stab_d;
            count_q   <= count_d;
            borrow_q  <= borrow_d;
        end
    end

    always_comb begin
        bus.leds = 7'h00;
        case (count_q)
            4'h0: bus.leds = 7'h3F;
            4'h1: bus.leds = 7'h06;
            4'h2: bus.leds = 7'h5B;
            4'h3: bus.leds = 7'h4F;
            4'h4: bus.leds = 7'h66;
            4'h5: bus.leds = 7'h6D;
            4'h6: bus.leds = 7'h7D;
            4'h7: bus.leds = 7'h07;
            4'h8: bus.leds = 7'h7F;
            4'h9: bus.leds = 7'h6F;
            4'hA: bus.leds = 7'h77;
            4'hB: bus.leds = 7'h7C;
            4'hC: bus.leds = 7'h39;
            4'hD: bus.leds = 7'h5E;
            4'hE: bus.leds = 7'h79;
            4'hF: bus.leds = 7'h71;
            default: bus.leds = 7'h00;
        endcase
    end

    assign bus.ano    = bus.an;
    assign bus.count  = count_q;
    assign bus.borrow = borrow_q;
endmodule

// File: doc/synchronous_down_counter.md
# synchronous_down_counter

Synchronous 4-bit binary down counter with a synchronous load and a built-in debouncer on the manual step key. Each clean press decrements the count; a press at 0 wraps to 15 and pulses `borrow`. The count drives a 7-segment digit, and the anode enables pass straight through. It is the counting-down counterpart of the lab's ripple up-counter and fits the same board display path, but every flop is clocked by `system_clk`.

## Interface
- `DEBOUNCE_CYCLES`, default 20000: consecutive `system_clk` cycles a synchronized key level must hold before it is accepted. Legal values are ≥ 2.
- `system_clk` input, 1 bit: the only clock. All state updates on its rising edge.
- `reset` input, 1 bit: synchronous, active-high reset.
- `key_i` input, 1 bit: raw, asynchronous, bouncing step button. Active-high.
- `load` input, 1 bit: synchronous load strobe, already clean.
- `din` input, 4 bits: load value.
- `an` input, 4 bits: anode enables.
- `ano` output, 4 bits: anode enables, equal to `an` combinationally.
- `count` output, 4 bits: current counter value, registered.
- `leds` output, 7 bits: segment pattern for `count`. Active-high; bit 0 = a … bit 6 = g.
- `borrow` output, 1 bit: one-cycle pulse on the wrap 0→15. Registered.

## Operation
**Synchronizer**
- Two flops, `k1` then `k2`, sample `key_i`.

**Debouncer**
- Holds the accepted level `kdb` and a stability counter `stab`, sized to reach `DEBOUNCE_CYCLES-1`.
- When `k2 == kdb`: `stab` clears to 0.
- Otherwise: `stab` increments.
- When `k2 != kdb` and `stab == DEBOUNCE_CYCLES-1`: `kdb` takes `k2` and `stab` clears.
- Any bounce back to `kdb` before that point restarts the count.

**Step strobe**
- `step` = `kdb` rising edge, detected with `kdb_d` (`kdb` delayed one cycle).
- `step` is exactly one cycle long per accepted press.
- Key release generates nothing.

**Counter priority (highest first)**
1. `reset`: `count`←0, `borrow`←0.
2. `load`: `count`←`din`, `borrow`←0.
3. `step`: `count`←`count`−1 modulo 16.
   - `borrow`←1 only if the old `count` was 0.
4. Otherwise: `count` holds, `borrow`←0.

**Boundary rules**
- `load` and `step` in the same cycle: the load wins and the step is discarded, not deferred.
- `borrow` never stays high for two consecutive cycles. Back-to-back steps need at least `2*DEBOUNCE_CYCLES` cycles between them, so this cannot arise from steps alone.
- `din` = 0 loaded, then one step: `count` becomes 15 and `borrow` pulses.

**Segment decode**
- Combinational from `count`. Hex glyphs 0..F: 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71.

## Timing
**Reset values**
- Reset clears `k1`, `k2`, `kdb`, `kdb_d`, `stab`, `count` and `borrow`.
- After reset: `count`=0, `leds`=7'h3F, `borrow`=0, and `ano` follows `an`.

**Reset mid-operation**
- A debounce in progress is abandoned.
- If `key_i` is held high through reset release, it is re-qualified from scratch. It produces exactly one step after the normal latency.

**Step latency**
- Take `key_i` rising clean before edge E0, with E0 the first edge sampling it high, and held high.
- `k2` is high after E1.
- `kdb` rises after edge E(1+`DEBOUNCE_CYCLES`).
- `count` changes, and `borrow` asserts if wrapping, after edge E(2+`DEBOUNCE_CYCLES`).
- With `DEBOUNCE_CYCLES`=4, this is 7 edges counting E0 as edge 1.

**Load latency**
- `count` shows `din` after the edge that samples `load`=1.

**Outputs**
- `leds` and `ano` are combinational, with no extra latency.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4.
1. **Reset:** assert `reset` for 2 cycles with `key_i`=0. Require `count`=0, `leds`=7'h3F, `borrow`=0, and `ano`=`an` for `an`=4'b1010.
2. **Clean press and wrap:** hold `key_i` high for 10 cycles, then low for 10. Require `count` 0→15 exactly once, 7 edges after the press, with `borrow`=1 for exactly that one cycle. Require `leds`=7'h71, and no change on release.
3. **Bounce:** toggle `key_i` high 3 / low 1 / high 2 / low 2 cycles, then hold high 6 cycles. Require exactly one decrement, occurring 7 edges after the start of the final stable high, with no extra steps.
4. **Load priority:** with `count`=15, assert `load`=1 and `din`=4'd9 in the same cycle `step` fires. Require `count`=9, `leds`=7'h6F, `borrow`=0, and no decrement afterwards.
5. **Count-down sequence:** load 3, then apply 4 clean presses. Require `count` 2,1,0,15, with `borrow` high only on the 0→15 step.
6. **Reset mid-debounce:** raise `key_i` and assert `reset` 2 cycles later for 1 cycle while `key_i` stays high. Require `count`=0 after reset, then exactly one step 7 edges after reset deasserts, giving `count`=15.
